// File: rtl/fpga_cfg_loader.sv
// ---------------------------------------------------------------------------
// fpga_cfg_loader
//   Takes a byte-wide configuration bitstream and shifts it, MSB first, into
//   a fabric configuration chain. Exactly 8*NBYTES bits are shifted per
//   session. When the bitstream is not a whole number of bytes long, the
//   leading pad bits fall out of the tail of the chain. Once the last bit is
//   shifted, fabric_reset is held for RST_HOLD more cycles and then released.
//
// Ports
//   prog_clk      : clock
//   reset         : asynchronous active-low reset
//   cfg_start     : one-cycle pulse that opens a session (from IDLE/DONE/ERROR)
//   cfg_data      : bitstream byte; the MSB is shifted first
//   cfg_valid     : cfg_data/cfg_last valid (held by the source until accepted)
//   cfg_last      : marks the final byte of the session
//   cfg_ready     : loader takes a byte this cycle
//   ccff_head     : serial data to the chain (registered)
//   prog_clk_en   : clock-gate enable for the fabric prog_clk (registered)
//   fabric_reset  : active-high fabric user reset; low only in DONE
//   cfg_busy      : session in progress (LOAD/SHIFT/HOLD)
//   cfg_done      : session completed
//   cfg_error     : session aborted because cfg_last was misplaced
// ---------------------------------------------------------------------------
module fpga_cfg_loader #(
  parameter int CHAIN_LEN = 128,
  parameter int RST_HOLD  = 4
) (
  input  logic       prog_clk,
  input  logic       reset,
  input  logic       cfg_start,
  input  logic [7:0] cfg_data,
  input  logic       cfg_valid,
  input  logic       cfg_last,
  output logic       cfg_ready,
  output logic       ccff_head,
  output logic       prog_clk_en,
  output logic       fabric_reset,
  output logic       cfg_busy,
  output logic       cfg_done,
  output logic       cfg_error
);

  localparam int NBYTES = (CHAIN_LEN + 7) / 8;
  localparam int NBITS  = 8 * NBYTES;
  localparam int BCW    = $clog2(NBYTES + 1);
  localparam int TCW    = $clog2(NBITS + 1);

  localparam logic [BCW-1:0] NBYTES_C   = BCW'(NBYTES);
  localparam logic [BCW-1:0] LAST_IDX_C = BCW'(NBYTES - 1);
  localparam logic [BCW-1:0] BYTE_ONE   = BCW'(1);
  localparam logic [TCW-1:0] NBITS_C    = TCW'(NBITS);
  localparam logic [TCW-1:0] BIT_ONE    = TCW'(1);
  localparam logic [7:0]     HOLD_END_C = 8'(RST_HOLD - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_ERROR = 3'd5;

  logic [2:0]     r_state;
  logic [7:0]     r_hold_data;
  logic           r_hold_full;
  logic [7:0]     r_sr;
  logic [3:0]     r_sr_cnt;    // bits still to shift out of r_sr
  logic [BCW-1:0] r_byte_cnt;  // bytes accepted this session
  logic [TCW-1:0] r_bit_cnt;   // bits placed on ccff_head this session
  logic [7:0]     r_hold_cnt;
  logic           r_ccff;
  logic           r_pce;

  logic w_active;
  logic w_shift;
  logic w_sr_take;
  logic w_ready;
  logic w_accept;
  logic w_idx_last;
  logic w_err;
  logic w_shift_done;

  assign w_active = (r_state == S_LOAD) || (r_state == S_SHIFT);
  assign w_shift  = (r_state == S_SHIFT) && (r_sr_cnt != 4'd0);

  // The shift register takes the held byte either when it is empty or while
  // its last bit is going out. Reloading on that last bit keeps a steady
  // supply of bytes shifting with no gap between them.
  assign w_sr_take = w_active && r_hold_full &&
                     ((r_sr_cnt == 4'd0) || (w_shift && (r_sr_cnt == 4'd1)));

  // No byte is accepted beyond the NBYTES-th, so the byte counter cannot wrap.
  assign w_ready = w_active && (r_byte_cnt != NBYTES_C) &&
                   (!r_hold_full || w_sr_take);

  assign w_accept   = cfg_valid && w_ready;
  assign w_idx_last = (r_byte_cnt == LAST_IDX_C);

  // cfg_last must appear exactly on byte NBYTES: early last and missing last
  // are both fatal to the session.
  assign w_err = w_accept && (cfg_last != w_idx_last);

  // All bits have been issued. The final bit is on ccff_head with
  // prog_clk_en high during this cycle. The hold period counts from the
  // next cycle.
  assign w_shift_done = (r_state == S_SHIFT) && (r_bit_cnt == NBITS_C);

  always_ff @(posedge prog_clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_hold_data <= 8'h00;
      r_hold_full <= 1'b0;
      r_sr        <= 8'h00;
      r_sr_cnt    <= 4'd0;
      r_byte_cnt  <= '0;
      r_bit_cnt   <= '0;
      r_hold_cnt  <= 8'h00;
      r_ccff      <= 1'b0;
      r_pce       <= 1'b0;
    end else begin
      // Only a live shift drives the chain; every other cycle idles it.
      r_ccff <= 1'b0;
      r_pce  <= 1'b0;

      case (r_state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (cfg_start) begin
            r_state     <= S_LOAD;
            r_hold_full <= 1'b0;
            r_hold_data <= 8'h00;
            r_sr        <= 8'h00;
            r_sr_cnt    <= 4'd0;
            r_byte_cnt  <= '0;
            r_bit_cnt   <= '0;
            r_hold_cnt  <= 8'h00;
          end
        end

        S_LOAD, S_SHIFT: begin
          if (w_err) begin
            // Stop at once. The bit in flight is not clocked into the chain.
            r_state <= S_ERROR;
          end else begin
            if (w_shift) begin
              r_ccff    <= r_sr[7];
              r_pce     <= 1'b1;
              r_bit_cnt <= r_bit_cnt + BIT_ONE;
            end

            if (w_sr_take) begin
              r_sr     <= r_hold_data;
              r_sr_cnt <= 4'd8;
            end else if (w_shift) begin
              r_sr     <= {r_sr[6:0], 1'b0};
              r_sr_cnt <= r_sr_cnt - 4'd1;
            end

            if (w_accept) begin
              r_hold_data <= cfg_data;
              r_hold_full <= 1'b1;
              r_byte_cnt  <= r_byte_cnt + BYTE_ONE;
            end else if (w_sr_take) begin
              r_hold_full <= 1'b0;
            end

            if ((r_state == S_LOAD) && w_sr_take) begin
              r_state <= S_SHIFT;
            end

            if (w_shift_done) begin
              r_state    <= S_HOLD;
              r_hold_cnt <= 8'h00;
            end
          end
        end

        S_HOLD: begin
          if (r_hold_cnt == HOLD_END_C) begin
            r_state <= S_DONE;
          end else begin
            r_hold_cnt <= r_hold_cnt + 8'd1;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cfg_ready    = w_ready;
  assign ccff_head    = r_ccff;
  assign prog_clk_en  = r_pce;
  assign fabric_reset = (r_state != S_DONE);
  assign cfg_busy     = (r_state == S_LOAD) || (r_state == S_SHIFT) ||
                        (r_state == S_HOLD);
  assign cfg_done     = (r_state == S_DONE);
  assign cfg_error    = (r_state == S_ERROR);

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// Bench for fpga_cfg_loader. Two instances share the clock and reset.
// dut runs with CHAIN_LEN=16 and d12 runs with CHAIN_LEN=12. Expected
// chain bits go into a scoreboard queue as bytes are accepted. Bits seen
// on ccff_head while prog_clk_en is high are collected, then popped and
// compared.
module tb_fpga_cfg_loader;
  localparam int RH = 4;

  logic prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;

  logic       reset;
  logic       cfg_start, cfg_valid, cfg_last;
  logic [7:0] cfg_data;
  logic       cfg_ready, ccff_head, prog_clk_en, fabric_reset;
  logic       cfg_busy, cfg_done, cfg_error;

  logic       start_b, valid_b, last_b;
  logic [7:0] data_b;
  logic       ready_b, ccff_b, pce_b, fab_b, busy_b, done_b, err_b;

  fpga_cfg_loader #(.CHAIN_LEN(16), .RST_HOLD(RH)) dut (
    .prog_clk(prog_clk), .reset(reset), .cfg_start(cfg_start),
    .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_last(cfg_last),
    .cfg_ready(cfg_ready), .ccff_head(ccff_head), .prog_clk_en(prog_clk_en),
    .fabric_reset(fabric_reset), .cfg_busy(cfg_busy), .cfg_done(cfg_done),
    .cfg_error(cfg_error));

  fpga_cfg_loader #(.CHAIN_LEN(12), .RST_HOLD(RH)) d12 (
    .prog_clk(prog_clk), .reset(reset), .cfg_start(start_b),
    .cfg_data(data_b), .cfg_valid(valid_b), .cfg_last(last_b),
    .cfg_ready(ready_b), .ccff_head(ccff_b), .prog_clk_en(pce_b),
    .fabric_reset(fab_b), .cfg_busy(busy_b), .cfg_done(done_b),
    .cfg_error(err_b));

  int total = 0;
  int bad   = 0;

  bit exp_q[$];
  bit got_q[$];
  int pce_cnt, first_pce, last_pce;
  int cyc = 0;
  logic [11:0] chain12;
  int pce12;

  always @(posedge prog_clk) cyc++;

  always @(negedge prog_clk) begin
    if (prog_clk_en === 1'b1) begin
      got_q.push_back(ccff_head);
      pce_cnt++;
      if (first_pce < 0) first_pce = cyc;
      last_pce = cyc;
    end
    if (pce_b === 1'b1) begin
      chain12 = {chain12[10:0], ccff_b};
      pce12++;
    end
  end

  task automatic tick;
    @(posedge prog_clk);
    #1;
  endtask

  task automatic clear_mon;
    got_q.delete();
    exp_q.delete();
    pce_cnt   = 0;
    first_pce = -1;
    last_pce  = -1;
  endtask

  task automatic pulse_start(input bit sel);
    if (sel) start_b = 1'b1; else cfg_start = 1'b1;
    tick();
    start_b   = 1'b0;
    cfg_start = 1'b0;
  endtask

  task automatic send_byte(input bit sel, input logic [7:0] d, input logic last,
                           input bit track);
    bit acc = 1'b0;
    if (sel) begin data_b = d; last_b = last; valid_b = 1'b1; end
    else begin cfg_data = d; cfg_last = last; cfg_valid = 1'b1; end
    for (int n = 0; n < 100 && !acc; n++) begin
      @(negedge prog_clk);
      acc = sel ? ready_b : cfg_ready;
      @(posedge prog_clk);
      #1;
    end
    valid_b   = 1'b0;
    cfg_valid = 1'b0;
    total++;
    if (!acc) begin
      bad++;
      $display("FAIL send_byte_accept: data=%h ready=0 after 100 cycles, required 1", d);
    end else if (track) begin
      for (int i = 7; i >= 0; i--) exp_q.push_back(d[i]);
    end
  endtask

  task automatic wait_end(input bit sel, input int maxc, output int e);
    e = -1;
    for (int n = 0; n < maxc; n++) begin
      @(negedge prog_clk);
      if (sel ? (done_b | err_b) : (cfg_done | cfg_error)) begin
        e = cyc;
        break;
      end
    end
  endtask

  // Drains both queues into vectors (oldest bit ends up most significant).
  task automatic pack(output logic [31:0] gv, output logic [31:0] ev,
                      output int gn, output int en);
    gv = '0; ev = '0; gn = 0; en = 0;
    while (got_q.size() > 0) begin gv = {gv[30:0], got_q.pop_front()}; gn++; end
    while (exp_q.size() > 0) begin ev = {ev[30:0], exp_q.pop_front()}; en++; end
  endtask

  task automatic test_reset;
    logic [6:0] o;
    reset = 1'b0;
    cfg_start = 0; cfg_valid = 0; cfg_last = 0; cfg_data = 0;
    start_b = 0; valid_b = 0; last_b = 0; data_b = 0;
    clear_mon();
    repeat (3) tick();
    o = {cfg_ready, ccff_head, prog_clk_en, fabric_reset, cfg_busy, cfg_done, cfg_error};
    total++;
    if (o !== 7'b0001000) begin
      bad++; $display("FAIL reset_outputs: got=%b required=0001000", o);
    end
    reset = 1'b1;
    repeat (4) tick();
    o = {cfg_ready, ccff_head, prog_clk_en, fabric_reset, cfg_busy, cfg_done, cfg_error};
    total++;
    if (o !== 7'b0001000 || pce_cnt !== 0) begin
      bad++; $display("FAIL reset_release_idle: got=%b pce=%0d required=0001000 pce=0", o, pce_cnt);
    end
  endtask

  task automatic test_basic;
    logic [31:0] gv, ev;
    int gn, en, e;
    logic [6:0] o;
    clear_mon();
    pulse_start(0);
    total++;
    if ({cfg_busy, fabric_reset, cfg_ready} !== 3'b111) begin
      bad++; $display("FAIL basic_load: busy/fab/ready=%b required 111", {cfg_busy, fabric_reset, cfg_ready});
    end
    send_byte(0, 8'hA5, 1'b0, 1);
    send_byte(0, 8'h3C, 1'b1, 1);
    wait_end(0, 200, e);
    pack(gv, ev, gn, en);
    total++;
    if (gn !== en || gv !== ev || gv[15:0] !== 16'hA53C) begin
      bad++; $display("FAIL basic_bits: got=%h/%0d required=%h/%0d", gv, gn, ev, en);
    end
    total++;
    if (last_pce - first_pce !== 15) begin
      bad++; $display("FAIL basic_contiguous: span=%0d required=15", last_pce - first_pce);
    end
    total++;
    if (e - last_pce - 1 !== RH) begin
      bad++; $display("FAIL basic_hold: hold=%0d required=%0d", e - last_pce - 1, RH);
    end
    o = {fabric_reset, ccff_head, prog_clk_en, cfg_ready, cfg_busy, cfg_done, cfg_error};
    total++;
    if (o !== 7'b0000010) begin
      bad++; $display("FAIL basic_done: got=%b required=0000010", o);
    end
  endtask

  task automatic test_chain12;
    int e;
    chain12 = 12'hFFF;
    pce12   = 0;
    pulse_start(1);
    send_byte(1, 8'hF0, 1'b0, 0);
    send_byte(1, 8'h0F, 1'b1, 0);
    wait_end(1, 200, e);
    tick();
    total++;
    if (chain12 !== 12'h00F || pce12 !== 16 || done_b !== 1'b1 || fab_b !== 1'b0) begin
      bad++; $display("FAIL chain12: chain=%h pce=%0d done=%b fab=%b required 00f 16 1 0",
                      chain12, pce12, done_b, fab_b);
    end
  endtask

  task automatic test_errors;
    int n;
    // cfg_last on byte 1 of 2
    clear_mon();
    pulse_start(0);
    send_byte(0, 8'h11, 1'b1, 0);
    tick();
    total++;
    if ({cfg_error, fabric_reset, cfg_busy, cfg_ready, prog_clk_en} !== 5'b11000 || pce_cnt !== 0) begin
      bad++; $display("FAIL err_early_last: err/fab/busy/rdy/pce=%b pce_cnt=%0d required 11000 0",
                      {cfg_error, fabric_reset, cfg_busy, cfg_ready, prog_clk_en}, pce_cnt);
    end
    cfg_valid = 1'b1; cfg_data = 8'h77; cfg_last = 1'b1;
    repeat (10) tick();
    cfg_valid = 1'b0;
    total++;
    if (pce_cnt !== 0 || cfg_error !== 1'b1 || cfg_ready !== 1'b0) begin
      bad++; $display("FAIL err_stays: pce_cnt=%0d err=%b rdy=%b required 0 1 0", pce_cnt, cfg_error, cfg_ready);
    end
    // byte 2 of 2 without cfg_last
    clear_mon();
    pulse_start(0);
    send_byte(0, 8'h22, 1'b0, 0);
    send_byte(0, 8'h33, 1'b0, 0);
    total++;
    if (cfg_error !== 1'b1 || prog_clk_en !== 1'b0 || fabric_reset !== 1'b1) begin
      bad++; $display("FAIL err_missing_last: err/pce/fab=%b required 101",
                      {cfg_error, prog_clk_en, fabric_reset});
    end
    n = pce_cnt;
    repeat (12) tick();
    total++;
    if (pce_cnt !== n) begin
      bad++; $display("FAIL err_no_more_pce: pce_cnt=%0d required %0d", pce_cnt, n);
    end
  endtask

  task automatic test_random_valid;
    logic [31:0] gv, ev;
    int gn, en, e;
    for (int s = 0; s < 3; s++) begin
      clear_mon();
      pulse_start(0);
      for (int b = 0; b < 2; b++) begin
        repeat ($urandom_range(0, 12)) tick();
        send_byte(0, 8'($urandom_range(0, 255)), (b == 1), 1);
      end
      wait_end(0, 300, e);
      pack(gv, ev, gn, en);
      total++;
      if (gn !== 16 || en !== 16 || gv !== ev || cfg_done !== 1'b1) begin
        bad++; $display("FAIL random_valid[%0d]: got=%h/%0d required=%h/%0d done=%b",
                        s, gv, gn, ev, en, cfg_done);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] gv, ev;
    int gn, en, e, n;
    logic [6:0] o;
    clear_mon();
    pulse_start(0);
    send_byte(0, 8'hC3, 1'b0, 0);
    send_byte(0, 8'h5A, 1'b1, 0);
    repeat (3) tick();
    #2;
    reset = 1'b0;
    #1;
    o = {cfg_ready, ccff_head, prog_clk_en, fabric_reset, cfg_busy, cfg_done, cfg_error};
    total++;
    if (o !== 7'b0001000) begin
      bad++; $display("FAIL reset_mid_outputs: got=%b required=0001000", o);
    end
    tick();
    reset = 1'b1;
    n = pce_cnt;
    repeat (8) tick();
    total++;
    if (pce_cnt !== n || cfg_busy !== 1'b0) begin
      bad++; $display("FAIL reset_mid_quiet: pce_cnt=%0d busy=%b required %0d 0", pce_cnt, cfg_busy, n);
    end
    clear_mon();
    pulse_start(0);
    send_byte(0, 8'h96, 1'b0, 1);
    send_byte(0, 8'h69, 1'b1, 1);
    wait_end(0, 200, e);
    pack(gv, ev, gn, en);
    total++;
    if (gn !== 16 || gv !== ev || cfg_done !== 1'b1) begin
      bad++; $display("FAIL reset_mid_fresh: got=%h/%0d required=%h/%0d done=%b", gv, gn, ev, en, cfg_done);
    end
  endtask

  task automatic test_restart;
    logic [31:0] gv, ev;
    int gn, en, e;
    clear_mon();
    pulse_start(0);
    send_byte(0, 8'hE1, 1'b0, 1);
    repeat (3) tick();
    pulse_start(0);
    send_byte(0, 8'h1E, 1'b1, 1);
    wait_end(0, 200, e);
    pack(gv, ev, gn, en);
    total++;
    if (gn !== 16 || gv !== ev || cfg_done !== 1'b1 || cfg_error !== 1'b0) begin
      bad++; $display("FAIL start_in_shift: got=%h/%0d required=%h/%0d done=%b err=%b",
                      gv, gn, ev, en, cfg_done, cfg_error);
    end
    tick();
    clear_mon();
    pulse_start(0);
    total++;
    if ({fabric_reset, cfg_done, cfg_busy, cfg_ready} !== 4'b1011) begin
      bad++; $display("FAIL restart_from_done: fab/done/busy/rdy=%b required 1011",
                      {fabric_reset, cfg_done, cfg_busy, cfg_ready});
    end
    send_byte(0, 8'h81, 1'b0, 1);
    send_byte(0, 8'h7E, 1'b1, 1);
    wait_end(0, 200, e);
    pack(gv, ev, gn, en);
    total++;
    if (gn !== 16 || gv !== ev || cfg_done !== 1'b1) begin
      bad++; $display("FAIL restart_session: got=%h/%0d required=%h/%0d done=%b", gv, gn, ev, en, cfg_done);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_chain12();
    test_errors();
    test_random_valid();
    test_reset_mid();
    test_restart();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
